// File: rtl/time_display_driver.sv
// time_display_driver: filters the binary hours/minutes from the time-of-day
// counter until they are stable and in range, converts them to BCD with a
// sequential double-dabble engine and commits all four 7-segment digits on
// one edge.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks hex3 when the hours
// tens digit is 0.
module time_display_driver #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] hours,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       busy,
  output logic       range_err
);

  localparam logic [3:0] SC        = 4'(STABLE_CYCLES);
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX3_RST  = SEG_BLANK;
`else
  localparam logic [6:0] HEX3_RST  = SEG_ZERO;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [11:0] cur;          // {hours, minutes} as presented this cycle
  logic [11:0] sample;
  logic [11:0] committed;
  logic [11:0] target;       // value being converted, becomes committed
  logic [3:0]  stable_cnt;
  logic        err_seen;     // current bad value already reported
  logic        range_err_nxt;
  logic [5:0]  work_h, work_m;
  logic [7:0]  bcd_h, bcd_m;
  logic [7:0]  adj_h, adj_m;
  logic [2:0]  shift_cnt;
  logic        stable_new, in_range, shifting, start;

  // active-low gfedcba; anything above 9 is blanked
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // double-dabble correction: +3 on every nibble that is 5 or more
  function automatic logic [7:0] add3(input logic [7:0] b);
    add3[7:4] = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    add3[3:0] = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
  endfunction

  assign cur        = {hours, minutes};
  assign stable_new = (stable_cnt == SC) && (sample != committed);
  assign in_range   = (sample[11:6] <= 6'd23) && (sample[5:0] <= 6'd59);
  assign adj_h      = add3(bcd_h);
  assign adj_m      = add3(bcd_m);
  assign busy       = (state != IDLE);
  // The datapath is primed on the edge that enters LOAD, so LOAD itself
  // performs the first of the six shift steps and SHIFT the remaining five.
  assign start      = (state == IDLE) && (state_nxt == LOAD);
  assign shifting   = (state == LOAD) || (state == SHIFT);

  // stability filter: runs in every state, independent of the FSM
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sample     <= '0;
      stable_cnt <= SC;
    end else begin
      sample <= cur;
      if (cur != sample)
        stable_cnt <= 4'd1;
      else if (stable_cnt < SC)
        stable_cnt <= stable_cnt + 4'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and the range-error decision
  always_comb begin
    state_nxt     = state;
    range_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (stable_new) begin
          if (in_range)       state_nxt     = LOAD;
          else if (!err_seen) range_err_nxt = 1'b1;
        end
      end
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == 3'd1) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // range error pulse; a bad value is reported once until the input changes
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      range_err <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      range_err <= range_err_nxt;
      if (cur != sample)      err_seen <= 1'b0;
      else if (range_err_nxt) err_seen <= 1'b1;
    end
  end

  // conversion datapath: hours and minutes shifted in parallel
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      target    <= '0;
      work_h    <= '0;
      work_m    <= '0;
      bcd_h     <= '0;
      bcd_m     <= '0;
      shift_cnt <= '0;
    end else if (start) begin
      target    <= sample;
      work_h    <= sample[11:6];
      work_m    <= sample[5:0];
      bcd_h     <= '0;
      bcd_m     <= '0;
      shift_cnt <= 3'd6;
    end else if (shifting) begin
      bcd_h     <= {adj_h[6:0], work_h[5]};
      bcd_m     <= {adj_m[6:0], work_m[5]};
      work_h    <= {work_h[4:0], 1'b0};
      work_m    <= {work_m[4:0], 1'b0};
      shift_cnt <= shift_cnt - 3'd1;
    end
  end

  // atomic commit of all four digits
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      hex0      <= SEG_ZERO;
      hex1      <= SEG_ZERO;
      hex2      <= SEG_ZERO;
      hex3      <= HEX3_RST;
      committed <= '0;
    end else if (state == COMMIT) begin
      hex0      <= seg7(bcd_m[3:0]);
      hex1      <= seg7(bcd_m[7:4]);
      hex2      <= seg7(bcd_h[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
      hex3      <= (bcd_h[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_h[7:4]);
`else
      hex3      <= seg7(bcd_h[7:4]);
`endif
      committed <= target;
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver: directed and randomized checks of the display
// driver against a cycle-level behavioural model built from decimal arithmetic.
module tb_time_display_driver;
  localparam int SC = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SB = 7'b1111111;
  localparam logic [27:0] D0000 = {(LZB ? SB : S0), S0, S0, S0};
  localparam logic [27:0] D2359 = {S2, S3, S5, S9};
  localparam logic [27:0] D1235 = {S1, S2, S3, S5};
  localparam logic [27:0] D1300 = {S1, S3, S0, S0};
  localparam logic [27:0] D0745 = {(LZB ? SB : S0), S7, S4, S5};

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] minutes = '0, hours = '0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       busy, range_err;
  int checks = 0, errors = 0;

  time_display_driver #(.STABLE_CYCLES(SC)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .minutes(minutes), .hours(hours),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .busy(busy), .range_err(range_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // model state; values are kept as hours*100+minutes
  int m_samp, m_cnt, m_comm, m_left, m_pend;
  bit m_errseen, m_err;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d >= 0 && d <= 9) ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [27:0] disp(input int v);
    int h, m;
    h = v / 100;
    m = v % 100;
    return {((LZB && h / 10 == 0) ? 7'b1111111 : seg(h / 10)), seg(h % 10),
            seg(m / 10), seg(m % 10)};
  endfunction

  task automatic model_reset();
    m_samp = 0; m_cnt = SC; m_comm = 0; m_left = 0; m_pend = 0;
    m_errseen = 1'b0; m_err = 1'b0;
  endtask

  task automatic set_in(input int v);
    hours   = 6'(v / 100);
    minutes = 6'(v % 100);
  endtask

  // one clock edge; the model advances with the inputs seen at that edge
  task automatic tick();
    int v;
    @(posedge clk_50MHz);
    v = int'(hours) * 100 + int'(minutes);
    if (reset) begin
      model_reset();
    end else begin
      m_err = 1'b0;
      if (m_left == 0) begin
        if (m_cnt == SC && m_samp != m_comm) begin
          if (m_samp / 100 <= 23 && m_samp % 100 <= 59) begin
            m_left = 7;           // converter occupied for seven cycles
            m_pend = m_samp;
          end else if (!m_errseen) begin
            m_err = 1'b1;
            m_errseen = 1'b1;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_comm = m_pend;
      end
      if (v != m_samp) begin
        m_cnt = 1;
        m_errseen = 1'b0;
      end else if (m_cnt < SC) begin
        m_cnt++;
      end
      m_samp = v;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    set_in(0);
    repeat (3) tick();
    #4 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({hex3, hex2, hex1, hex0} !== D0000 || busy !== 1'b0 || range_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: hex=%h busy=%b err=%b, want hex=%h busy=0 err=0",
                 k, {hex3, hex2, hex1, hex0}, busy, range_err, D0000);
      end
    end
  endtask

  task automatic test_basic();
    set_in(2359);
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (busy !== (k >= 2 && k <= 8)) begin
        errors++;
        $display("FAIL basic_busy E0+%0d: got %b want %b", k, busy, (k >= 2 && k <= 8));
      end
      checks++;
      if ({hex3, hex2, hex1, hex0} !== ((k >= 9) ? D2359 : D0000)) begin
        errors++;
        $display("FAIL basic_hex E0+%0d: got %h want %h", k, {hex3, hex2, hex1, hex0},
                 (k >= 9) ? D2359 : D0000);
      end
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 10; i++) begin
      set_in((i % 2 == 0) ? 1235 : 1234);
      tick();
      checks++;
      if (busy !== 1'b0 || {hex3, hex2, hex1, hex0} !== D2359) begin
        errors++;
        $display("FAIL toggle_quiet cyc %0d: busy=%b hex=%h want busy=0 hex=%h",
                 i, busy, {hex3, hex2, hex1, hex0}, D2359);
      end
    end
    set_in(1235);
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if ({hex3, hex2, hex1, hex0} !== ((k >= 9) ? D1235 : D2359) || busy !== (m_left != 0)) begin
        errors++;
        $display("FAIL toggle_hold E0+%0d: hex=%h busy=%b want hex=%h busy=%b", k,
                 {hex3, hex2, hex1, hex0}, busy, (k >= 9) ? D1235 : D2359, (m_left != 0));
      end
    end
  endtask

  task automatic test_range();
    int pulses = 0;
    set_in(1260);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (range_err === 1'b1) pulses++;
      checks++;
      if (busy !== 1'b0 || {hex3, hex2, hex1, hex0} !== D1235) begin
        errors++;
        $display("FAIL range_hold cyc %0d: busy=%b hex=%h want busy=0 hex=%h",
                 k, busy, {hex3, hex2, hex1, hex0}, D1235);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL range_pulses: got %0d want 1", pulses);
    end
    set_in(1300);
    repeat (12) tick();
    checks++;
    if ({hex3, hex2, hex1, hex0} !== D1300) begin
      errors++;
      $display("FAIL range_recover: got %h want %h", {hex3, hex2, hex1, hex0}, D1300);
    end
  endtask

  task automatic test_reset_mid();
    set_in(745);
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got %b want 1", busy);
    end
    #4 reset = 1'b1;
    #1;
    checks++;
    if ({hex3, hex2, hex1, hex0} !== D0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: hex=%h busy=%b want hex=%h busy=0",
               {hex3, hex2, hex1, hex0}, busy, D0000);
    end
    repeat (2) tick();
    #4 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if ({hex3, hex2, hex1, hex0} !== ((k >= 9) ? D0745 : D0000)) begin
        errors++;
        $display("FAIL midrst_after E0+%0d: got %h want %h", k, {hex3, hex2, hex1, hex0},
                 (k >= 9) ? D0745 : D0000);
      end
    end
  endtask

  task automatic test_random();
    int v, hold;
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 7))
        0:       v = int'($urandom_range(24, 63)) * 100 + int'($urandom_range(0, 63));
        1:       v = int'($urandom_range(0, 23)) * 100 + int'($urandom_range(60, 63));
        2:       v = m_comm;
        default: v = int'($urandom_range(0, 23)) * 100 + int'($urandom_range(0, 59));
      endcase
      set_in(v);
      hold = $urandom_range(1, 14);
      for (int k = 0; k < hold; k++) begin
        tick();
        checks++;
        if ({hex3, hex2, hex1, hex0} !== disp(m_comm) || busy !== (m_left != 0) ||
            range_err !== m_err) begin
          errors++;
          $display("FAIL random it %0d in %0d: hex=%h busy=%b err=%b want hex=%h busy=%b err=%b",
                   it, v, {hex3, hex2, hex1, hex0}, busy, range_err, disp(m_comm),
                   (m_left != 0), m_err);
        end
      end
    end
    set_in(2038);
    repeat (20) tick();
    checks++;
    if ({hex3, hex2, hex1, hex0} !== disp(2038) || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_final: hex=%h busy=%b want hex=%h busy=0",
               {hex3, hex2, hex1, hex0}, busy, disp(2038));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
